// File: rtl/mha_pkg.sv
// Shared constants and types for the multi-head-attention tile path.
// Row and tile are packed so a whole tile can cross a port as one vector.
package mha_pkg;

  localparam int ROWS  = 16;
  localparam int COLS  = 128;
  localparam int DW    = 8;
  localparam int SEL_W = 8;
  localparam int RC_W  = $clog2(ROWS);

  typedef logic [0:COLS-1][DW-1:0] row_t;
  typedef logic [0:ROWS-1][0:COLS-1][DW-1:0] tile_t;

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/mat_tile_writer.sv
// Collects up to ROWS int8 rows into one tile buffer, then presents it to the
// BRAM tile store and holds it stable until the store signals completion.
module mat_tile_writer
  import mha_pkg::*;
(
  input  logic             I_CLK,
  input  logic             I_RST_N,
  input  logic             I_ROW_VLD,
  output logic             O_ROW_RDY,
  input  row_t             I_ROW,
  input  logic             I_ROW_LAST,
  input  logic [SEL_W-1:0] I_SEL,
  output logic             O_WR_ENA,
  output logic [SEL_W-1:0] O_SEL,
  output tile_t            O_MAT,
  input  logic             I_WR_DONE,
  output logic             O_TILE_DONE,
  output logic             O_BUSY
);

  wr_state_t       state;
  logic [RC_W-1:0] row_cnt;
  logic            hs;
  logic            tile_end;
  logic            fill_hs;

  assign hs       = I_ROW_VLD & O_ROW_RDY;
  assign tile_end = (row_cnt == RC_W'(ROWS - 1)) | I_ROW_LAST;
  assign fill_hs  = (state == S_FILL) & hs;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state       <= S_FILL;
      row_cnt     <= '0;
      O_ROW_RDY   <= 1'b0;
      O_WR_ENA    <= 1'b0;
      O_TILE_DONE <= 1'b0;
      O_BUSY      <= 1'b0;
      O_SEL       <= '0;
    end else begin
      O_TILE_DONE <= 1'b0;
      case (state)
        S_FILL: begin
          O_ROW_RDY <= 1'b1;
          if (hs) begin
            if (row_cnt == '0) O_SEL <= I_SEL;
            if (tile_end) begin
              state     <= S_WRITE;
              O_ROW_RDY <= 1'b0;
              O_WR_ENA  <= 1'b1;
              O_BUSY    <= 1'b1;
              row_cnt   <= '0;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        S_WRITE: begin
          // Dropping the request on the done edge keeps the store from re-arming.
          if (I_WR_DONE) begin
            state       <= S_FILL;
            O_WR_ENA    <= 1'b0;
            O_BUSY      <= 1'b0;
            O_TILE_DONE <= 1'b1;
            O_ROW_RDY   <= 1'b1;
          end
        end
      endcase
    end
  end

  // One register row per tile line; rows past the last accepted one are zeroed
  // on the closing handshake so short tiles never carry stale data.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      row_t row_q;

      always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
          row_q <= '0;
        end else if (fill_hs) begin
          if (row_cnt == RC_W'(gi)) begin
            row_q <= I_ROW;
          end else if (tile_end && (RC_W'(gi) > row_cnt)) begin
            row_q <= '0;
          end
        end
      end

      assign O_MAT[gi] = row_q;
    end
  endgenerate

endmodule
